// File: rtl/axi_apb_burst_bridge_pkg.sv
// Shared types and constants for the AXI4-to-APB3 burst bridge.
// Holds the FSM state encoding, response codes and 4 KB page address helper.
package axi_apb_bridge_pkg;

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP} state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int          BEAT_BYTES  = 4;
  localparam logic [11:0] PAGE_MASK   = 12'hFFC;

  // Next word inside the same 4 KB page; byte-lane bits ride along untouched.
  function automatic logic [11:0] page_incr(input logic [11:0] offs);
    return (((offs & PAGE_MASK) + 12'(BEAT_BYTES)) & PAGE_MASK) | (offs & ~PAGE_MASK);
  endfunction

endpackage

// File: rtl/axi_apb_burst_bridge_if.sv
// AXI4 slave port plus APB3 master port of the burst bridge.
// slave = bridge side, master = interconnect/peripheral environment side.
interface axi_apb_burst_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      aw_valid, aw_ready;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic                      w_valid, w_ready;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [3:0]                w_strb;
  logic                      w_last;
  logic                      b_valid, b_ready;
  logic [1:0]                b_resp;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic                      ar_valid, ar_ready;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic                      r_valid, r_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_ADDR_WIDTH-1:0] paddr;
  logic [AXI_DATA_WIDTH-1:0] pwdata, prdata;
  logic                      pwrite, psel, penable, pready, pslverr;

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_id, output aw_ready,
    input  w_valid, w_data, w_strb, w_last,  output w_ready,
    output b_valid, b_resp, b_id,            input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_id, output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, input r_ready,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport master (
    output aw_valid, aw_addr, aw_len, aw_id, input aw_ready,
    output w_valid, w_data, w_strb, w_last,  input w_ready,
    input  b_valid, b_resp, b_id,            output b_ready,
    output ar_valid, ar_addr, ar_len, ar_id, input ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id, output r_ready,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axi_apb_burst_bridge.sv
// AXI4 slave to APB3 master bridge: bursts are split into single-word APB
// accesses, reads and writes share one FSM with alternating arbitration.
module axi_apb_burst_bridge
  import axi_apb_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  axi_apb_burst_bridge_if.slave  bus
);

  if (AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axi_apb_burst_bridge supports only 32-bit data");
  end

  state_e                    state;
  logic                      prefer_wr;
  logic                      idle_rdy;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q, beat_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      err_q;

  logic rd_pick, aw_hs, ar_hs, beat_last, err_beat, wr_beat_done;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;

  // Readies are only offered in IDLE and never both at once.
  assign rd_pick     = bus.ar_valid & (~bus.aw_valid | ~prefer_wr);
  assign bus.ar_ready = idle_rdy & rd_pick;
  assign bus.aw_ready = idle_rdy & bus.aw_valid & ~rd_pick;
  assign aw_hs       = bus.aw_valid & bus.aw_ready;
  assign ar_hs       = bus.ar_valid & bus.ar_ready;
  assign bus.paddr   = addr_q;

  assign beat_last = (beat_q == len_q);
  assign next_addr = {addr_q[AXI_ADDR_WIDTH-1:12], page_incr(addr_q[11:0])};

  // Error flag as it stands once the current write beat has been accounted for.
  always_comb begin
    err_beat = err_q | bus.pslverr;
    if (state == WDATA)
      err_beat = err_q | (bus.w_last != beat_last) | (bus.w_strb != 4'hF);
  end

  assign wr_beat_done = ((state == WDATA) && bus.w_valid && bus.w_ready && (bus.w_strb != 4'hF)) ||
                        ((state == ACCESS) && bus.pready && bus.pwrite);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prefer_wr   <= 1'b0;
      idle_rdy    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      bus.w_ready <= 1'b0;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.pwdata  <= '0;
      bus.r_valid <= 1'b0;
      bus.r_data  <= '0;
      bus.r_resp  <= RESP_OKAY;
      bus.r_last  <= 1'b0;
      bus.r_id    <= '0;
      bus.b_valid <= 1'b0;
      bus.b_resp  <= RESP_OKAY;
      bus.b_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_rdy <= 1'b1;
          if (aw_hs) begin
            idle_rdy    <= 1'b0;
            prefer_wr   <= ~prefer_wr;
            addr_q      <= bus.aw_addr;
            len_q       <= bus.aw_len;
            id_q        <= bus.aw_id;
            beat_q      <= '0;
            err_q       <= 1'b0;
            bus.pwrite  <= 1'b1;
            bus.w_ready <= 1'b1;
            state       <= WDATA;
          end else if (ar_hs) begin
            idle_rdy   <= 1'b0;
            prefer_wr  <= ~prefer_wr;
            addr_q     <= bus.ar_addr;
            len_q      <= bus.ar_len;
            id_q       <= bus.ar_id;
            beat_q     <= '0;
            err_q      <= 1'b0;
            bus.pwrite <= 1'b0;
            bus.psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        WDATA: if (bus.w_valid) begin
          bus.w_ready <= 1'b0;
          bus.pwdata  <= bus.w_data;
          err_q       <= err_beat;
          if (bus.w_strb == 4'hF) begin
            bus.psel <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: if (bus.pready) begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          if (!bus.pwrite) begin
            bus.r_valid <= 1'b1;
            bus.r_data  <= bus.prdata;
            bus.r_resp  <= bus.pslverr ? RESP_SLVERR : RESP_OKAY;
            bus.r_last  <= beat_last;
            bus.r_id    <= id_q;
            state       <= RDATA;
          end
        end
        RDATA: if (bus.r_ready) begin
          bus.r_valid <= 1'b0;
          bus.r_last  <= 1'b0;
          if (beat_last) begin
            idle_rdy <= 1'b1;
            state    <= IDLE;
          end else begin
            beat_q   <= beat_q + 8'd1;
            addr_q   <= next_addr;
            bus.psel <= 1'b1;
            state    <= SETUP;
          end
        end
        BRESP: if (bus.b_ready) begin
          bus.b_valid <= 1'b0;
          idle_rdy    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared end of a write beat, reached from WDATA (strobe reject) or ACCESS.
      if (wr_beat_done) begin
        err_q <= err_beat;
        if (beat_last) begin
          bus.b_valid <= 1'b1;
          bus.b_resp  <= err_beat ? RESP_SLVERR : RESP_OKAY;
          bus.b_id    <= id_q;
          state       <= BRESP;
        end else begin
          beat_q      <= beat_q + 8'd1;
          addr_q      <= next_addr;
          bus.w_ready <= 1'b1;
          state       <= WDATA;
        end
      end
    end
  end

endmodule

// File: doc/axi_apb_burst_bridge.md
Name: axi_apb_burst_bridge

Overview:
- Converts the AXI4 peripheral slave port of the system interconnect (0x1A10_0000–0x1A11_FFFF window) into APB3 transfers for the peripheral subsystem.
- Bursts are split into single-word APB accesses.
- Reads and writes are serialised through one FSM with fair arbitration.
- Sits directly downstream of the AXI interconnect slave port and upstream of the APB peripheral bus.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI/APB address width.
- AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- AXI_ID_WIDTH, 4, slave-side ID width, echoed on B/R.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- aw_valid/aw_ready  in/out  1  write address handshake
- aw_addr  in  AXI_ADDR_WIDTH  burst start address
- aw_len  in  8  beats minus one
- aw_id  in  AXI_ID_WIDTH  write ID
- w_valid/w_ready  in/out  1  write data handshake
- w_data  in  32  write data
- w_strb  in  4  byte strobes
- w_last  in  1  last write beat
- b_valid/b_ready  out/in  1  write response handshake
- b_resp  out  2  write response
- b_id  out  AXI_ID_WIDTH  response ID
- ar_valid/ar_ready  in/out  1  read address handshake
- ar_addr  in  AXI_ADDR_WIDTH  read start address
- ar_len  in  8  beats minus one
- ar_id  in  AXI_ID_WIDTH  read ID
- r_valid/r_ready  out/in  1  read data handshake
- r_data  out  32  read data
- r_resp  out  2  read response
- r_last  out  1  last read beat
- r_id  out  AXI_ID_WIDTH  read ID
- paddr  out  AXI_ADDR_WIDTH  APB address
- pwdata  out  32  APB write data
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- **Reset:** all outputs 0, FSM in IDLE, arbitration flag prefers read. Reset is asynchronous mid-transfer: psel/penable/r_valid/b_valid drop immediately, and the burst is abandoned.
- **FSM states:** IDLE, WDATA, SETUP, ACCESS, RDATA, BRESP.
- **IDLE:**
  - At most one of aw_ready/ar_ready is high.
  - If both valid, serve the direction not served last; the flag toggles on each accepted address.
  - On handshake, latch addr, len and id, clear the beat counter and error flag.
  - AW → WDATA; AR → SETUP.
- **WDATA:** w_ready=1. On handshake, latch w_data, then:
  - if w_strb != 4'hF: set error flag, skip APB, go to the next beat;
  - else go to SETUP.
- **SETUP:** psel=1, penable=0, pwrite set by direction; lasts exactly 1 cycle, then ACCESS.
- **ACCESS:**
  - psel=1, penable=1, held until pready.
  - On pready, write: OR pslverr into the error flag.
  - On pready, read: register prdata into r_data and r_resp = pslverr ? 2'b10 : 2'b00, go to RDATA.
- **RDATA:**
  - r_valid held, data stable until r_ready.
  - r_last=1 on beat == len.
  - On handshake, advance to SETUP, or to IDLE after the last beat.
- **Write beat end:**
  - Advance to WDATA if beats remain, else BRESP.
  - w_last value differing from (beat == len) sets the error flag; the beat count always governs.
- **BRESP:** b_valid held until b_ready; b_resp = error ? 2'b10 : 2'b00; then IDLE.
- **Addressing:**
  - paddr = latched address with bits [11:2] incremented by 1 per beat, modulo 4 KB; upper bits and [1:0] unchanged.
  - Burst type and size are ignored: always INCR, 4 bytes.
- **Counters:** 8-bit beat counter; aw_len = 255 gives 256 beats.
- **Minimum latency, zero wait states:**
  - Write: AW hs c0, W hs c1, SETUP c2, ACCESS c3, b_valid c4.
  - Read: AR hs c0, SETUP c1, ACCESS c2, r_valid c3.
- No outstanding transactions; new addresses are accepted only in IDLE.

Decomposition:
- Package axi_apb_bridge_pkg holds:
  - state enum typedef;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - BEAT_BYTES=4, PAGE_MASK=12'hFFC.
- Single module. The APB phase sequencer is inline; no sub-module is warranted.

Test Plan:
- Single write: aw_addr=0x1A10_0008, len=0, w_data=0xDEADBEEF, strb=F, pready=1 → APB write to 0x1A10_0008 with SETUP then ACCESS, b_valid at c4, b_resp=00.
- Read burst: ar_addr=0x1A10_1FF8, len=3, r_ready=1 → paddr 0x1A10_1FF8, 0x1A10_1FFC, 0x1A10_1000, 0x1A10_1004 (4 KB wrap), r_last only on beat 4.
- Wait states and backpressure: pready low 3 cycles, r_ready low 2 cycles → penable held 4 cycles, r_data stable while r_valid high.
- Errors:
  - write len=1 with pslverr on beat 0 → both beats issued, b_resp=10;
  - write beat with strb=4'h3 → no APB access for that beat, b_resp=10.
- Arbitration: aw_valid and ar_valid asserted together, twice in a row → read served first, write second; IDs echoed on r_id/b_id.
- Reset mid-ACCESS → psel/penable drop in the same cycle; after release, a fresh single read completes normally.
